// File: rtl/router_input_buffer.sv
// Per-port input FIFO of the credit-based router: buffers flits, requests routing per header and
// streams each packet to the crossbar. Optional counters under ROUTER_INPUT_BUFFER_STATS_EN.
module router_input_buffer #(
  parameter int unsigned FLIT_WIDTH   = 16,
  parameter int unsigned BUFFER_DEPTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rx,
  input  logic [FLIT_WIDTH-1:0] data_in,
  output logic                  credit_o,
  output logic                  h,
  input  logic                  ack_h,
  output logic                  data_av,
  output logic [FLIT_WIDTH-1:0] data,
  input  logic                  data_ack,
  output logic                  sender
`ifdef ROUTER_INPUT_BUFFER_STATS_EN
  ,
  output logic [31:0]                   stat_pkts,
  output logic [$clog2(BUFFER_DEPTH):0] stat_hwm
`endif
);

  localparam int unsigned PtrW = $clog2(BUFFER_DEPTH);
  localparam int unsigned OccW = PtrW + 1;
  localparam logic [OccW-1:0] OccFull = OccW'(BUFFER_DEPTH);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StReq     = 3'd1;
  localparam logic [2:0] StHeader  = 3'd2;
  localparam logic [2:0] StSize    = 3'd3;
  localparam logic [2:0] StPayload = 3'd4;

  logic [FLIT_WIDTH-1:0] mem_q [BUFFER_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [OccW-1:0]       occ_q, occ_d;
  logic [2:0]            state_q, state_d;
  logic [FLIT_WIDTH-1:0] cnt_q, cnt_d;
  logic                  empty, wr_en, pop, pkt_done;

  assign empty    = (occ_q == '0);
  assign credit_o = (occ_q != OccFull);
  assign wr_en    = rx & credit_o;
  assign pop      = data_av & data_ack;
  assign data     = empty ? '0 : mem_q[rd_ptr_q];

  assign h       = (state_q == StReq);
  assign sender  = (state_q == StHeader) | (state_q == StSize) | (state_q == StPayload);
  assign data_av = sender & ~empty;

  // A zero size flit closes the packet right after the size flit itself.
  assign pkt_done = pop & (((state_q == StSize) & (data == '0)) |
                           ((state_q == StPayload) & (cnt_q <= FLIT_WIDTH'(1))));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle:   if (!empty) state_d = StReq;
      StReq:    if (ack_h) state_d = StHeader;
      StHeader: if (pop) state_d = StSize;
      StSize: begin
        if (pop) begin
          cnt_d   = data;
          state_d = pkt_done ? StIdle : StPayload;
        end
      end
      StPayload: begin
        if (pop) begin
          if (cnt_q != '0) cnt_d = cnt_q - FLIT_WIDTH'(1);
          if (pkt_done) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    occ_d = occ_q;
    case ({wr_en, pop})
      2'b10:   occ_d = occ_q + OccW'(1);
      2'b01:   occ_d = occ_q - OccW'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      state_q  <= StIdle;
      cnt_q    <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + PtrW'(1);
      occ_q   <= occ_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_ptr_q] <= data_in;
  end

`ifdef ROUTER_INPUT_BUFFER_STATS_EN
  logic [31:0]     pkts_q;
  logic [OccW-1:0] hwm_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pkts_q <= '0;
      hwm_q  <= '0;
    end else begin
      if (pkt_done) pkts_q <= pkts_q + 32'd1;
      if (occ_d > hwm_q) hwm_q <= occ_d;
    end
  end

  assign stat_pkts = pkts_q;
  assign stat_hwm  = hwm_q;
`endif

endmodule
